rv32i_alu_reg: RTL and testbench
================================

Name: rv32i_alu_reg

Overview:
- RV32I integer ALU for the execute stage: add/sub, shifts, signed/unsigned compare, logic ops.
- Operation is selected by funct3 plus op_sign, which carries instruction bit 30 for SUB/SRA.
- The combinational datapath feeds a single output register stage, so latency is one cycle.
- Outputs are the 32-bit result plus zero, negative and overflow flags for the branch/control logic.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; the shift amount is always op_b[4:0].

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode are valid this cycle.
- op_a  in  32  operand A (rs1).
- op_b  in  32  operand B (rs2 or immediate).
- funct3  in  3  operation select.
- op_sign  in  1  alternate-op select: SUB when funct3=000, SRA when funct3=101.
- out_valid  out  1  result and flags hold a fresh result.
- result  out  32  registered result.
- zero  out  1  registered (result == 0).
- negative  out  1  registered result[31].
- overflow  out  1  registered signed overflow of ADD/SUB.

Behaviour:
- Always-on clock; asynchronous active-low reset on resetn.
- Reset values: result=0, zero=1, negative=0, overflow=0, out_valid=0.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge. Nothing in flight survives reset.
- Each rising clk edge: out_valid <= in_valid.
- If in_valid=1, result and all flags load the value computed from the current inputs.
- If in_valid=0, result and flags hold their previous values.
- Latency 1 cycle; one new operation accepted every cycle, back-to-back, no stall.
- Operation decode:
  - 000: op_sign=0 ADD (op_a+op_b); op_sign=1 SUB (op_a-op_b). Both mod 2^32.
  - 001: SLL, op_a << op_b[4:0].
  - 010: SLT, 1 if $signed(op_a) < $signed(op_b), else 0. Must be correct even when op_a-op_b overflows.
  - 011: SLTU, 1 if op_a < op_b unsigned, else 0.
  - 100: XOR.
  - 101: op_sign=0 SRL (zero fill); op_sign=1 SRA (sign fill from op_a[31]). Shift amount op_b[4:0].
  - 110: OR.
  - 111: AND.
- op_sign is ignored for funct3 other than 000 and 101.
- op_b[31:5] is ignored for all shifts. A shift amount of 0 returns op_a unchanged.
- Flag rules:
  - zero = (result == 0) for every operation.
  - negative = result[31] for every operation, so SLT/SLTU always give 0.
  - overflow = signed overflow of ADD/SUB only; 0 for every other funct3.
  - ADD overflow: operand signs equal and result sign differs.
  - SUB overflow: operand signs differ and result sign differs from op_a.

Optional Feature:
- Macro ALU_CARRY_OUT_EN.
- When defined: adds output port carry (1 bit), registered with the other flags, reset value 0.
  - ADD: carry = bit 32 of op_a+op_b.
  - SUB: carry = carry-out of op_a + ~op_b + 1, i.e. 1 when no borrow (op_a >= op_b unsigned).
  - All other operations: carry = 0.
- When not defined: the port does not exist and the carry logic is absent. All other behaviour is identical.

Test Plan:
- Reset: assert resetn=0 mid-stream, asynchronously between clock edges -> result=0, zero=1, negative=0, overflow=0, out_valid=0 immediately.
- ADD and SUB:
  - 12+13 -> 0x00000019, flags 0/0/0.
  - 11-13 (op_sign=1) -> 0xFFFFFFFE, negative=1.
  - 0x7FFFFFFF+1 -> 0x80000000, overflow=1, negative=1.
  - 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
  - With ALU_CARRY_OUT_EN: 0xFFFFFFFF+1 -> 0, zero=1, carry=1.
- Shifts:
  - SLL 0x10000000 by 2 -> 0x40000000.
  - SRA 0xFFFF0001 by 2 -> 0xFFFFC000.
  - SRL 0x10000000 by 7 -> 0x00200000.
  - SLL with op_b=0x00000022 -> shift by 2 (upper bits ignored).
- Compares:
  - SLT -18 vs 14 -> 1.
  - SLTU 18 vs 15 -> 0, zero=1.
  - SLTU 0xFFFFFFEE vs 14 -> 0.
  - SLT 0x80000000 vs 0x7FFFFFFF -> 1.
- Logic:
  - XOR 0xFFFF0000^0x0000FFFF -> 0xFFFFFFFF, negative=1.
  - OR 0x10000000|0xE0000000 -> 0xF0000000.
  - AND of the same operands -> 0x00000000, zero=1.
- Pipelining and hold:
  - Issue ADD/SUB/XOR on consecutive cycles -> each result appears exactly one cycle later, out_valid=1 each cycle.
  - Drop in_valid -> out_valid=0 next cycle, result and flags unchanged.

Source files
------------

// File: rtl/rv32i_alu_reg_if.sv
// Operand/opcode request and registered result/flag bundle for rv32i_alu_reg.
// The carry signal exists only when ALU_CARRY_OUT_EN is defined.
interface rv32i_alu_reg_if;
  logic        in_valid;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  funct3;
  logic        op_sign;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        overflow;
`ifdef ALU_CARRY_OUT_EN
  logic        carry;

  modport master (
    output in_valid, op_a, op_b, funct3, op_sign,
    input  out_valid, result, zero, negative, overflow, carry
  );
  modport slave (
    input  in_valid, op_a, op_b, funct3, op_sign,
    output out_valid, result, zero, negative, overflow, carry
  );
`else
  modport master (
    output in_valid, op_a, op_b, funct3, op_sign,
    input  out_valid, result, zero, negative, overflow
  );
  modport slave (
    input  in_valid, op_a, op_b, funct3, op_sign,
    output out_valid, result, zero, negative, overflow
  );
`endif
endinterface

// File: rtl/rv32i_alu_reg.sv
// RV32I execute-stage ALU with a single output register stage (latency 1).
// Define ALU_CARRY_OUT_EN to add a registered carry flag for ADD/SUB.
module rv32i_alu_reg #(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            resetn,
  rv32i_alu_reg_if.slave bus
);

  logic [XLEN-1:0] a_w;
  logic [XLEN-1:0] b_w;
  logic [XLEN-1:0] b_add_w;
  logic [XLEN-1:0] sum_w;
  logic [XLEN-1:0] alu_w;
  logic [4:0]      shamt_w;
  logic            is_sub_w;
  logic            ovf_w;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            negative_q, negative_d;
  logic            overflow_q, overflow_d;

  assign a_w      = bus.op_a;
  assign b_w      = bus.op_b;
  assign shamt_w  = bus.op_b[4:0];
  assign is_sub_w = (bus.funct3 == 3'b000) && bus.op_sign;
  // SUB is a + ~b + 1 so the same adder yields both overflow and carry rules.
  assign b_add_w  = is_sub_w ? ~b_w : b_w;

`ifdef ALU_CARRY_OUT_EN
  logic carry_w;
  logic carry_q, carry_d;
  assign {carry_w, sum_w} = {1'b0, a_w} + {1'b0, b_add_w} + {{XLEN{1'b0}}, is_sub_w};
`else
  assign sum_w = a_w + b_add_w + {{(XLEN-1){1'b0}}, is_sub_w};
`endif

  assign ovf_w = (a_w[XLEN-1] == b_add_w[XLEN-1]) && (sum_w[XLEN-1] != a_w[XLEN-1]);

  always_comb begin
    alu_w = '0;
    unique case (bus.funct3)
      3'b000: alu_w = sum_w;
      3'b001: alu_w = a_w << shamt_w;
      3'b010: alu_w = {{(XLEN-1){1'b0}}, ($signed(a_w) < $signed(b_w))};
      3'b011: alu_w = {{(XLEN-1){1'b0}}, (a_w < b_w)};
      3'b100: alu_w = a_w ^ b_w;
      3'b101: alu_w = bus.op_sign ? XLEN'($signed(a_w) >>> shamt_w) : (a_w >> shamt_w);
      3'b110: alu_w = a_w | b_w;
      3'b111: alu_w = a_w & b_w;
      default: alu_w = '0;
    endcase
  end

  always_comb begin
    valid_d    = bus.in_valid;
    result_d   = result_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    overflow_d = overflow_q;
`ifdef ALU_CARRY_OUT_EN
    carry_d    = carry_q;
`endif
    if (bus.in_valid) begin
      result_d   = alu_w;
      zero_d     = (alu_w == '0);
      negative_d = alu_w[XLEN-1];
      overflow_d = (bus.funct3 == 3'b000) && ovf_w;
`ifdef ALU_CARRY_OUT_EN
      carry_d    = (bus.funct3 == 3'b000) && carry_w;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef ALU_CARRY_OUT_EN
      carry_q    <= 1'b0;
`endif
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
`ifdef ALU_CARRY_OUT_EN
      carry_q    <= carry_d;
`endif
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.overflow  = overflow_q;
`ifdef ALU_CARRY_OUT_EN
  assign bus.carry     = carry_q;
`endif

endmodule

// File: tb/tb_rv32i_alu_reg.sv
// Table-driven scoreboard bench for rv32i_alu_reg: back-to-back vectors,
// hold on idle, and asynchronous reset mid-stream.
module tb_rv32i_alu_reg;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        sign;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        v;
    logic        c;
  } vec_t;

  logic clk;
  logic resetn;
  rv32i_alu_reg_if bus ();

  rv32i_alu_reg #(.XLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn      = 0;
  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t last_exp;

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] f3, logic sign,
                              logic [31:0] res, logic z, logic n, logic v, logic c);
    vec_t t;
    t.a = a; t.b = b; t.f3 = f3; t.sign = sign;
    t.res = res; t.z = z; t.n = n; t.v = v; t.c = c;
    return t;
  endfunction

  task automatic chk_word(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_bit(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_flags(string tag, vec_t e);
    chk_word({tag, ".result"},   bus.result,   e.res);
    chk_bit ({tag, ".zero"},     bus.zero,     e.z);
    chk_bit ({tag, ".negative"}, bus.negative, e.n);
    chk_bit ({tag, ".overflow"}, bus.overflow, e.v);
`ifdef ALU_CARRY_OUT_EN
    chk_bit ({tag, ".carry"},    bus.carry,    e.c);
`endif
  endtask

  task automatic drive(vec_t v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a     = v.a;
    bus.op_b     = v.b;
    bus.funct3   = v.f3;
    bus.op_sign  = v.sign;
    exp_q.push_back(v);
  endtask

  // Called #1 after a rising edge: the result of the previous drive must be there now.
  task automatic expect_out();
    vec_t e;
    chk_bit("out_valid", bus.out_valid, 1'b1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got output with empty queue, expected queued entry");
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      chk_flags($sformatf("txn%0d", txn), e);
      $display("txn %0d: f3=%0d sign=%0b a=0x%08h b=0x%08h -> res=0x%08h z=%0b n=%0b v=%0b",
               txn, e.f3, e.sign, e.a, e.b, bus.result, bus.zero, bus.negative, bus.overflow);
    end
    txn++;
  endtask

  task automatic chk_reset_state(string tag);
    chk_bit ({tag, ".out_valid"}, bus.out_valid, 1'b0);
    chk_word({tag, ".result"},    bus.result,    32'h0);
    chk_bit ({tag, ".zero"},      bus.zero,      1'b1);
    chk_bit ({tag, ".negative"},  bus.negative,  1'b0);
    chk_bit ({tag, ".overflow"},  bus.overflow,  1'b0);
`ifdef ALU_CARRY_OUT_EN
    chk_bit ({tag, ".carry"},     bus.carry,     1'b0);
`endif
  endtask

  initial begin
    //                a             b             f3    s     result        z     n     v     c
    vecs.push_back(mk(32'd12,       32'd13,       3'd0, 1'b0, 32'h00000019, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'd11,       32'd13,       3'd0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'h7FFFFFFF, 32'd1,        3'd0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'd1,        3'd0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(32'hFFFFFFFF, 32'd1,        3'd0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'd5,        32'd5,        3'd0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'h10000000, 32'd2,        3'd1, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFF0001, 32'd2,        3'd5, 1'b1, 32'hFFFFC000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'h10000000, 32'd7,        3'd5, 1'b0, 32'h00200000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00000003, 32'h00000022, 3'd1, 1'b0, 32'h0000000C, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h80000001, 32'h00000020, 3'd5, 1'b1, 32'h80000001, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'd31,       3'd5, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'd31,       3'd5, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFFFFEE, 32'd14,       3'd2, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'd18,       32'd15,       3'd3, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFFFFEE, 32'd14,       3'd3, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'h7FFFFFFF, 3'd2, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFF0000, 32'h0000FFFF, 3'd4, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'hA5A5A5A5, 32'h0F0F0F0F, 3'd4, 1'b1, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'h10000000, 32'hE0000000, 3'd6, 1'b0, 32'hF0000000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'h10000000, 32'hE0000000, 3'd7, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0));

    resetn       = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.funct3   = '0;
    bus.op_sign  = 1'b0;
    last_exp     = vecs[0];

    repeat (2) @(posedge clk);
    #1 chk_reset_state("por");
    @(negedge clk);
    resetn = 1'b1;

    // Back-to-back issue: in_valid stays high across the whole table.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1 expect_out();
    end

    // Idle cycles: out_valid drops, result/flags hold the last value.
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op_a     = 32'h12345678;
    bus.op_b     = 32'h1;
    bus.funct3   = 3'd0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk_bit("hold.out_valid", bus.out_valid, 1'b0);
      chk_flags($sformatf("hold%0d", k), last_exp);
      $display("idle %0d: out_valid=%0b res=0x%08h", k, bus.out_valid, bus.result);
    end

    // Load a non-reset-looking result, then reset asynchronously mid-cycle.
    drive(vecs[2]);
    @(posedge clk);
    #1 expect_out();
    #2 resetn = 1'b0;
    #1 chk_reset_state("async_rst");
    $display("async reset: out_valid=%0b res=0x%08h z=%0b", bus.out_valid, bus.result, bus.zero);
    exp_q.delete();
    @(posedge clk);
    #1 chk_reset_state("rst_held");
    @(negedge clk);
    resetn       = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 chk_reset_state("post_rst");

    // Traffic resumes normally after reset.
    drive(vecs[0]);
    @(posedge clk);
    #1 expect_out();
    @(negedge clk);
    bus.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
